fmap_reader: RTL and testbench
==============================

Name: fmap_reader

Overview:
- Reads the packed 8-bit feature map that the layer writeback stores in BRAM32k, unpacks it and feeds it to the next layer's PE groups as a byte-pair stream.
- Two BRAM32k read ports run in lockstep, one per channel group: port 1 (A) and port 2 (B).
- Byte order within a 64-bit word matches the writer: bits [63:56] first, [7:0] last.
- Output uses a valid/ready handshake. A one-word prefetch buffer per port sustains one pair per cycle while the consumer is ready.

Parameters:
- BASE_A, 0, first word address for port 1
- BASE_B, 128, first word address for port 2
- WORDS_PER_ROW, 4, 64-bit words per feature-map row (32 bytes)
- ROWS, 28, rows per frame
- ROW_STRIDE, 128, address step between consecutive rows

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse that begins a frame read; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final pair handshake
- en_BRAM32k  out  1  BRAM read enable
- addr_BRAM32k_1  out  12  port 1 word address
- addr_BRAM32k_2  out  12  port 2 word address
- dout_BRAM32k_1  in  64  port 1 read data, valid 1 cycle after en_BRAM32k
- dout_BRAM32k_2  in  64  port 2 read data
- out_valid  out  1  out_a/out_b/out_last valid
- out_ready  in  1  consumer accepts the pair
- out_a  out  8  signed byte from port 1
- out_b  out  8  signed byte from port 2
- out_last  out  1  marks the final pair of the frame

Behaviour:
- Reset: all outputs 0 and all internal state cleared. Addresses reset to BASE_A and BASE_B, both FSM-idle. Reset mid-frame aborts immediately; no done pulse.
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: issue reads and drain output. Moves to FIN when the last pair handshakes.
  - FIN: done=1 for one cycle, then IDLE.
- Addressing: word w (0..WORDS_PER_ROW-1) of row r (0..ROWS-1) is at BASE + r*ROW_STRIDE + w, computed as a 12-bit sum with natural wrap. Both ports use the same r and w.
- Read issue: a read is issued in a RUN cycle when all of the following hold:
  - words remain to be read;
  - no read is in flight;
  - the next-word buffer is empty, or the current word will be exhausted this cycle.
  - Issuing means en_BRAM32k=1 (registered) with the addresses; otherwise en_BRAM32k=0.
- Read return: returned data (1 cycle after en) goes to the current-word register if that register is empty or being exhausted this cycle; otherwise it goes to the next-word buffer. The next-word buffer refills the current register when the current word is exhausted.
- Byte index: a 3-bit index per current word. On index k, out_a=cur_a[63-8k -: 8] and out_b likewise from cur_b. The index increments on each handshake (out_valid & out_ready). After k=7 the word is exhausted and the index returns to 0.
- out_valid=1 exactly when the current register holds an unconsumed word.
- Stall: when out_ready=0, out_a, out_b and out_last stay stable.
- Latency: start is sampled at edge E0 and the first en_BRAM32k is high in the following cycle. out_valid first rises after E2, so first data is available 3 cycles after start.
- Throughput: with out_ready held at 1, pairs are continuous. There is no bubble at word or row boundaries.
- Frame size: 8*WORDS_PER_ROW*ROWS pairs. out_last=1 on the final pair only.
- start asserted in the same cycle as done, or while busy: ignored.

Optional Feature:
- FMAP_RELU_EN defined: out_a and out_b are forced to 8'h00 when the unpacked byte is negative (bit 7 set). This applies ReLU on read for layers that need it.
- FMAP_RELU_EN undefined: bytes pass through unchanged.

Test Plan:
- Preload addr 0 = 64'h0102030405060708 and addr 128 = 64'h1112131415161718 (ROWS=1, WORDS_PER_ROW=1), pulse start, hold out_ready=1.
  -> out_a = 01..08 and out_b = 11..18 on 8 consecutive cycles, first valid 3 cycles after start, out_last on the 08/18 pair, done one cycle later.
- Default parameters, out_ready=1 throughout.
  -> Addresses issued: 0,1,2,3,128,129,130,131,256,... on port 1 (port 2 offset +128).
  -> 896 pairs with no out_valid gap after the first; done after 896 handshakes.
- out_ready toggled 1,0,0,1 repeatedly.
  -> Outputs held stable while out_ready=0, no byte lost or duplicated; full sequence still matches the BRAM contents.
- Assert rst low mid-frame (after 20 pairs), release, pulse start.
  -> After reset: all outputs 0 and addresses at BASE. The new frame restarts at byte 0 of addr 0 with no stale data and no done pulse for the aborted frame.
- start pulsed again while busy.
  -> Ignored; frame length and addresses unchanged.
- With FMAP_RELU_EN: word 64'h80FF7F01_00000000.
  -> out_a = 00,00,7F,01,00,00,00,00. Without the macro: 80,FF,7F,01,00,00,00,00.

Source files
------------

// File: rtl/fmap_reader.sv
// Feature-map reader: streams packed 8-bit bytes from two lockstep BRAM32k ports as byte pairs.
// Optional FMAP_RELU_EN clamps negative unpacked bytes to zero on read.
module fmap_reader #(
  parameter int unsigned BASE_A        = 0,
  parameter int unsigned BASE_B        = 128,
  parameter int unsigned WORDS_PER_ROW = 4,
  parameter int unsigned ROWS          = 28,
  parameter int unsigned ROW_STRIDE    = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        en_BRAM32k,
  output logic [11:0] addr_BRAM32k_1,
  output logic [11:0] addr_BRAM32k_2,
  input  logic [63:0] dout_BRAM32k_1,
  input  logic [63:0] dout_BRAM32k_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_a,
  output logic [7:0]  out_b,
  output logic        out_last
);

  localparam int unsigned WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(WORDS_PER_ROW - 1);
  localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
  localparam logic [11:0]   BA     = 12'(BASE_A);
  localparam logic [11:0]   BB     = 12'(BASE_B);
  localparam logic [11:0]   RS     = 12'(ROW_STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_en;
  logic          r_en_last;
  logic          r_rvalid;
  logic          r_rv_last;
  logic [11:0]   r_addr_1;
  logic [11:0]   r_addr_2;
  logic [WW-1:0] r_word;
  logic [RW-1:0] r_row;
  logic [11:0]   r_row_off;
  logic          r_all_issued;

  logic [63:0]   r_cur_a;
  logic [63:0]   r_cur_b;
  logic          r_cur_valid;
  logic          r_cur_last;
  logic [63:0]   r_nxt_a;
  logic [63:0]   r_nxt_b;
  logic          r_nxt_valid;
  logic          r_nxt_last;
  logic [2:0]    r_idx;

  logic          w_hs;
  logic          w_exhaust;
  logic          w_issue;
  logic          w_last_word;
  logic [5:0]    w_sh;
  logic [63:0]   w_sh_a;
  logic [63:0]   w_sh_b;
  logic [7:0]    w_byte_a;
  logic [7:0]    w_byte_b;

  assign w_hs        = r_cur_valid & out_ready;
  assign w_exhaust   = w_hs & (r_idx == 3'd7);
  assign w_last_word = (r_word == LAST_W) && (r_row == LAST_R);

  // A read occupies two cycles (en, then data); one outstanding read keeps the two-word buffer from overflowing.
  always_comb begin
    w_issue = 1'b0;
    if (r_state == S_IDLE)
      w_issue = start;
    else if (r_state == S_RUN)
      w_issue = !r_all_issued && !r_en && !r_rvalid && (!r_nxt_valid || w_exhaust);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_hs && out_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Read issue: address counters and the read pipeline tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en         <= 1'b0;
      r_en_last    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rv_last    <= 1'b0;
      r_addr_1     <= BA;
      r_addr_2     <= BB;
      r_word       <= '0;
      r_row        <= '0;
      r_row_off    <= '0;
      r_all_issued <= 1'b0;
    end else begin
      r_en      <= w_issue;
      r_en_last <= w_issue & w_last_word;
      r_rvalid  <= r_en;
      r_rv_last <= r_en_last;
      if (w_issue) begin
        r_addr_1 <= BA + r_row_off + 12'(r_word);
        r_addr_2 <= BB + r_row_off + 12'(r_word);
        if (r_word == LAST_W) begin
          r_word    <= '0;
          r_row     <= r_row + RW'(1);
          r_row_off <= r_row_off + RS;
        end else begin
          r_word <= r_word + WW'(1);
        end
        if (w_last_word) r_all_issued <= 1'b1;
      end else if (r_state == S_FIN) begin
        r_word       <= '0;
        r_row        <= '0;
        r_row_off    <= '0;
        r_all_issued <= 1'b0;
      end
    end
  end

  // Current-word register and prefetch buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_a     <= '0;
      r_cur_b     <= '0;
      r_cur_valid <= 1'b0;
      r_cur_last  <= 1'b0;
      r_nxt_a     <= '0;
      r_nxt_b     <= '0;
      r_nxt_valid <= 1'b0;
      r_nxt_last  <= 1'b0;
      r_idx       <= '0;
    end else begin
      if (w_hs) r_idx <= r_idx + 3'd1;
      // Issue rules guarantee returning data never meets a full prefetch buffer.
      if (w_exhaust) begin
        if (r_nxt_valid) begin
          r_cur_a     <= r_nxt_a;
          r_cur_b     <= r_nxt_b;
          r_cur_last  <= r_nxt_last;
          r_nxt_valid <= 1'b0;
        end else if (r_rvalid) begin
          r_cur_a    <= dout_BRAM32k_1;
          r_cur_b    <= dout_BRAM32k_2;
          r_cur_last <= r_rv_last;
        end else begin
          r_cur_valid <= 1'b0;
        end
      end else if (r_rvalid) begin
        if (!r_cur_valid) begin
          r_cur_a     <= dout_BRAM32k_1;
          r_cur_b     <= dout_BRAM32k_2;
          r_cur_last  <= r_rv_last;
          r_cur_valid <= 1'b1;
        end else begin
          r_nxt_a     <= dout_BRAM32k_1;
          r_nxt_b     <= dout_BRAM32k_2;
          r_nxt_last  <= r_rv_last;
          r_nxt_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sh     = {r_idx, 3'b000};
    w_sh_a   = r_cur_a << w_sh;
    w_sh_b   = r_cur_b << w_sh;
    w_byte_a = w_sh_a[63:56];
    w_byte_b = w_sh_b[63:56];
  end

`ifdef FMAP_RELU_EN
  assign out_a = w_byte_a[7] ? 8'h00 : w_byte_a;
  assign out_b = w_byte_b[7] ? 8'h00 : w_byte_b;
`else
  assign out_a = w_byte_a;
  assign out_b = w_byte_b;
`endif

  assign out_valid      = r_cur_valid;
  assign out_last       = r_cur_valid & r_cur_last & (r_idx == 3'd7);
  assign en_BRAM32k     = r_en;
  assign addr_BRAM32k_1 = r_addr_1;
  assign addr_BRAM32k_2 = r_addr_2;

endmodule

// File: tb/tb_fmap_reader.sv
// Scoreboard bench for fmap_reader: expected pairs/addresses queued at start, checked by a negedge monitor.
module tb_fmap_reader;

  localparam int unsigned BASEA  = 0;
  localparam int unsigned BASEB  = 128;
  localparam int unsigned WPR    = 4;
  localparam int unsigned NROWS  = 28;
  localparam int unsigned STRIDE = 128;
  localparam int unsigned NPAIRS = 8 * WPR * NROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, en_BRAM32k, out_valid, out_last;
  logic [11:0] addr_BRAM32k_1, addr_BRAM32k_2;
  logic [63:0] dout_BRAM32k_1, dout_BRAM32k_2;
  logic [7:0]  out_a, out_b;

  logic [63:0] mem1 [4096];
  logic [63:0] mem2 [4096];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } pair_t;

  pair_t       exp_q[$];
  logic [23:0] addr_q[$];

  int nvec = 0;
  int nerr = 0;
  int npairs = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int rdy_mode = 0;

  always #5 clk = ~clk;

  fmap_reader #(
    .BASE_A(BASEA),
    .BASE_B(BASEB),
    .WORDS_PER_ROW(WPR),
    .ROWS(NROWS),
    .ROW_STRIDE(STRIDE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .en_BRAM32k(en_BRAM32k),
    .addr_BRAM32k_1(addr_BRAM32k_1),
    .addr_BRAM32k_2(addr_BRAM32k_2),
    .dout_BRAM32k_1(dout_BRAM32k_1),
    .dout_BRAM32k_2(dout_BRAM32k_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a(out_a),
    .out_b(out_b),
    .out_last(out_last)
  );

  always @(posedge clk) begin
    if (en_BRAM32k) begin
      dout_BRAM32k_1 <= mem1[addr_BRAM32k_1];
      dout_BRAM32k_2 <= mem2[addr_BRAM32k_2];
    end
  end

  function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef FMAP_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    logic [11:0] a1, a2;
    logic [63:0] w1, w2;
    pair_t p;
    for (int unsigned r = 0; r < NROWS; r++) begin
      for (int unsigned w = 0; w < WPR; w++) begin
        a1 = 12'(BASEA + r * STRIDE + w);
        a2 = 12'(BASEB + r * STRIDE + w);
        addr_q.push_back({a1, a2});
        for (int unsigned k = 0; k < 8; k++) begin
          w1 = mem1[a1] << (8 * k);
          w2 = mem2[a2] << (8 * k);
          p.a = relu(w1[63:56]);
          p.b = relu(w2[63:56]);
          p.last = (r == NROWS - 1) && (w == WPR - 1) && (k == 7);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", en_BRAM32k, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr1", addr_BRAM32k_1, BASEA);
    chk("rst_addr2", addr_BRAM32k_2, BASEB);
  endtask

  // Queue a frame, pulse start and check first-read/first-valid latency.
  task automatic launch();
    push_frame();
    npairs = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("lat_en", en_BRAM32k, 1);
    chk("lat_busy", busy, 1);
    chk("lat_valid_e0", out_valid, 0);
    @(posedge clk); #1 chk("lat_valid_e1", out_valid, 0);
    @(posedge clk); #1 chk("lat_valid_e2", out_valid, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    nvec++;
    nerr++;
    $display("FAIL done_timeout: got no done, expected done within 6000 cycles");
  endtask

  task automatic chk_frame_end();
    chk("frame_pairs", npairs, NPAIRS);
    chk("exp_q_left", exp_q.size(), 0);
    chk("addr_q_left", addr_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end
    end
  end

  // Monitor: pops and compares on every handshake and every BRAM read.
  initial begin
    logic        prev_last_hs;
    logic        prev_stall;
    logic [16:0] held;
    pair_t       e;
    logic [23:0] ea;
    prev_last_hs = 1'b0;
    prev_stall   = 1'b0;
    held         = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_last_hs = 1'b0;
        prev_stall   = 1'b0;
      end else begin
        chk("done_pulse", done, prev_last_hs);
        if (prev_stall) chk("stall_hold", {out_valid, out_a, out_b, out_last}, {1'b1, held});
        if (en_BRAM32k) begin
          if (addr_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL addr_extra: got %0h/%0h, expected no read", addr_BRAM32k_1, addr_BRAM32k_2);
          end else begin
            ea = addr_q.pop_front();
            chk("addr_pair", {addr_BRAM32k_1, addr_BRAM32k_2}, ea);
          end
        end
        if (out_valid && out_ready) begin
          if (npairs == 0) first_cyc = cyc;
          last_cyc = cyc;
          npairs++;
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL pair_extra: got %0h/%0h, expected no pair", out_a, out_b);
          end else begin
            e = exp_q.pop_front();
            chk("pair_a", out_a, e.a);
            chk("pair_b", out_b, e.b);
            chk("pair_last", out_last, e.last);
          end
        end
        prev_last_hs = out_valid & out_ready & out_last;
        prev_stall   = out_valid & ~out_ready;
        held         = {out_a, out_b, out_last};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] w1, w2;
    for (int i = 0; i < 4096; i++) begin
      w1 = '0;
      w2 = '0;
      for (int j = 0; j < 8; j++) begin
        w1 = {w1[55:0], 8'(i * 7 + j * 13 + 5)};
        w2 = {w2[55:0], 8'(i * 11 + j * 29 + 1)};
      end
      mem1[i] = w1;
      mem2[i] = w2;
    end
    mem1[0]   = 64'h0102030405060708;
    mem2[128] = 64'h1112131415161718;
    mem1[1]   = 64'h80FF7F0100000000;

    #2 rst = 1'b0;
    #3 chk_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Frame 1: consumer always ready, pairs must be back-to-back
    rdy_mode = 0;
    launch();
    wait_done();
    chk_frame_end();
    chk("no_gap_span", last_cyc - first_cyc, NPAIRS - 1);

    // Frame 2: ready 1,0,0,1 with start pulses while busy and in the done cycle
    rdy_mode = 1;
    launch();
    repeat (40) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk_frame_end();
    repeat (3) @(posedge clk);
    #1 chk("start_in_done_busy", busy, 0);
    chk("start_in_done_valid", out_valid, 0);
    rdy_mode = 0;

    // Frame 3: abort by reset after 20 pairs, then a clean frame
    launch();
    for (int i = 0; i < 200 && npairs < 20; i++) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    launch();
    wait_done();
    chk_frame_end();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
